// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the front-end hazard/stall controller:
// PC-mux encodings, controller states and register-file constants.
package hazard_stall_ctrl_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned PC_SEL_W = 2;
  localparam int unsigned REMAIN_W = 2;

  localparam logic [REG_W-1:0] REG_X0 = REG_W'(0);

  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEL_SEQ  = 2'b00,
    PC_SEL_BR   = 2'b01,
    PC_SEL_JAL  = 2'b10,
    PC_SEL_JALR = 2'b11
  } pc_sel_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-stage hazard inputs and front-end control outputs.
// master = pipeline side, slave = hazard controller.
interface hazard_stall_ctrl_if;
  import hazard_stall_ctrl_pkg::*;

  logic [REG_W-1:0]    Rs1_ID;
  logic [REG_W-1:0]    Rs2_ID;
  logic                UsesRs1;
  logic                UsesRs2;
  logic                IsBranch_ID;
  logic                JAL_ID;
  logic                JALR_ID;
  logic                branch_taken;
  logic [REG_W-1:0]    Rd_EX;
  logic                RegWrite_EX;
  logic                MemRead_EX;
  logic [REG_W-1:0]    Rd_MEM;
  logic                MemRead_MEM;
  logic                PCWrite;
  logic                IFID_Write;
  logic                MUXsel_Hazard;
  logic                IF_Flush;
  logic [PC_SEL_W-1:0] pc_sel;

  modport master (
    output Rs1_ID, Rs2_ID, UsesRs1, UsesRs2, IsBranch_ID, JAL_ID, JALR_ID,
           branch_taken, Rd_EX, RegWrite_EX, MemRead_EX, Rd_MEM, MemRead_MEM,
    input  PCWrite, IFID_Write, MUXsel_Hazard, IF_Flush, pc_sel
  );

  modport slave (
    input  Rs1_ID, Rs2_ID, UsesRs1, UsesRs2, IsBranch_ID, JAL_ID, JALR_ID,
           branch_taken, Rd_EX, RegWrite_EX, MemRead_EX, Rd_MEM, MemRead_MEM,
    output PCWrite, IFID_Write, MUXsel_Hazard, IF_Flush, pc_sel
  );

endinterface

// File: rtl/hazard_stall_ctrl_match.sv
// Combinational source/destination comparator: does a later-stage rd feed
// a register the decode-stage instruction actually reads? x0 never matches.
module hazard_match
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  output logic             hit_c
);

  assign hit_c = (rd != REG_X0) &&
                 ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// IF/ID front-end sequencer: load-use and branch/JALR operand stalls,
// PC-mux steering with IF/ID flush on redirect, saturating perf counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned LD_BR_STALLS = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  hazard_stall_ctrl_if.slave bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [REMAIN_W-1:0] LD_BR_NEED = REMAIN_W'(LD_BR_STALLS);

  state_e              state_q, state_d;
  logic [REMAIN_W-1:0] remain_q, remain_d;
  logic [REMAIN_W-1:0] need_c;
  logic                hit_ex_c, hit_mem_c, cf_c;
  logic                stall_c, hold_c, flush_c;
  pc_sel_e             redirect_c, pc_sel_c;

  hazard_match u_match_ex (
    .rd       (bus.Rd_EX),
    .rs1      (bus.Rs1_ID),
    .rs2      (bus.Rs2_ID),
    .uses_rs1 (bus.UsesRs1),
    .uses_rs2 (bus.UsesRs2),
    .hit_c    (hit_ex_c)
  );

  hazard_match u_match_mem (
    .rd       (bus.Rd_MEM),
    .rs1      (bus.Rs1_ID),
    .rs2      (bus.Rs2_ID),
    .uses_rs1 (bus.UsesRs1),
    .uses_rs2 (bus.UsesRs2),
    .hit_c    (hit_mem_c)
  );

  assign cf_c = bus.IsBranch_ID || bus.JALR_ID;

  // Required bubbles; the load-into-branch case is always the largest.
  always_comb begin
    need_c = '0;
    if (state_q == ST_RUN) begin
      if (bus.MemRead_EX && hit_ex_c && cf_c) begin
        need_c = LD_BR_NEED;
      end else if ((bus.MemRead_EX && hit_ex_c) ||
                   (bus.RegWrite_EX && hit_ex_c && cf_c) ||
                   (bus.MemRead_MEM && hit_mem_c && cf_c)) begin
        need_c = REMAIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    stall_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (need_c != '0) begin
          stall_c = 1'b1;
          if (need_c > REMAIN_W'(1)) begin
            remain_d = need_c - REMAIN_W'(1);
            state_d  = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        stall_c  = 1'b1;
        remain_d = remain_q - REMAIN_W'(1);
        if (remain_q == REMAIN_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d  = ST_RUN;
        remain_d = '0;
      end
    endcase
  end

  // Reset presents the same frozen front end as a stall cycle.
  always_comb begin
    hold_c            = stall_c || !reset_n;
    redirect_c        = PC_SEL_SEQ;
    if (bus.JALR_ID) begin
      redirect_c = PC_SEL_JALR;
    end else if (bus.JAL_ID) begin
      redirect_c = PC_SEL_JAL;
    end else if (bus.IsBranch_ID && bus.branch_taken) begin
      redirect_c = PC_SEL_BR;
    end
    pc_sel_c          = hold_c ? PC_SEL_SEQ : redirect_c;
    flush_c           = (pc_sel_c != PC_SEL_SEQ);
    bus.PCWrite       = !hold_c;
    bus.IFID_Write    = !hold_c;
    bus.MUXsel_Hazard = hold_c;
    bus.IF_Flush      = flush_c;
    bus.pc_sel        = pc_sel_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: hand-computed stall, redirect and
// counter expectations checked with immediate assertions.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  int          checks;
  int          errors;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(.CNT_W(32), .LD_BR_STALLS(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic pcw, input logic ifid,
                          input logic mux, input logic fl, input logic [1:0] sel);
    chk({tag, ".PCWrite"},       32'(bus.PCWrite),       32'(pcw));
    chk({tag, ".IFID_Write"},    32'(bus.IFID_Write),    32'(ifid));
    chk({tag, ".MUXsel_Hazard"}, 32'(bus.MUXsel_Hazard), 32'(mux));
    chk({tag, ".IF_Flush"},      32'(bus.IF_Flush),      32'(fl));
    chk({tag, ".pc_sel"},        32'(bus.pc_sel),        32'(sel));
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] s, input logic [31:0] f);
    chk({tag, ".stall_cnt"}, stall_cnt, s);
    chk({tag, ".flush_cnt"}, flush_cnt, f);
  endtask

  task automatic set_ex(input logic memrd, input logic regwr, input logic [4:0] rd);
    bus.MemRead_EX  = memrd;
    bus.RegWrite_EX = regwr;
    bus.Rd_EX       = rd;
  endtask

  task automatic set_mem(input logic memrd, input logic [4:0] rd);
    bus.MemRead_MEM = memrd;
    bus.Rd_MEM      = rd;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic br, input logic jal, input logic jalr,
                        input logic tk);
    bus.Rs1_ID       = rs1;
    bus.Rs2_ID       = rs2;
    bus.UsesRs1      = u1;
    bus.UsesRs2      = u2;
    bus.IsBranch_ID  = br;
    bus.JAL_ID       = jal;
    bus.JALR_ID      = jalr;
    bus.branch_taken = tk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b0, 5'd0);
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset: frozen front end, counters clear
    #3;
    chk_outs("reset", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    chk_cnt("reset", 32'd0, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // 1: load x5 in EX, ADD x6,x5,x7 in ID -> one bubble
    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("t1.stall", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b1, 5'd5);
    @(negedge clk);
    chk_outs("t1.release", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    chk_cnt("t1", 32'd1, 32'd0);
    tick();

    // 2: load x5 in EX, BEQ x5,x0 in ID -> two bubbles, then taken redirect
    set_mem(1'b0, 5'd0);
    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_outs("t2.stall1", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    set_ex(1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk_outs("t2.stall2", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    @(negedge clk);
    chk_outs("t2.redirect", 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
    tick();
    chk_cnt("t2", 32'd3, 32'd1);

    // 3: ADD x9 in EX, JALR x0,0(x9) in ID -> one bubble, then JALR redirect
    set_ex(1'b0, 1'b1, 5'd9);
    set_id(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_outs("t3.stall", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b0, 5'd9);
    @(negedge clk);
    chk_outs("t3.redirect", 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
    tick();
    chk_cnt("t3", 32'd4, 32'd2);

    // 4: JAL in ID with a load to x5 in EX -> no stall, immediate redirect
    set_mem(1'b0, 5'd0);
    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("t4.jal", 1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
    tick();
    chk_cnt("t4", 32'd4, 32'd3);

    // 5: load to x0 in EX, BNE x0 not taken -> no stall, no redirect
    set_ex(1'b1, 1'b1, 5'd0);
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("t5.x0", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();

    // Unused rs2 matching a load destination is not a hazard
    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("t5.unused_rs2", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    chk_cnt("t5", 32'd4, 32'd3);

    // Load in MEM feeding a branch rs2 -> one bubble, then taken redirect
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b1, 5'd3);
    set_id(5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_outs("mem.stall", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    set_mem(1'b0, 5'd0);
    @(negedge clk);
    chk_outs("mem.redirect", 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
    tick();
    chk_cnt("mem", 32'd5, 32'd4);

    // Load in MEM feeding a plain ALU op -> forwarded, no stall
    set_mem(1'b1, 5'd3);
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("mem.alu", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    set_mem(1'b0, 5'd0);

    // 6: reset in the middle of a load-branch stall
    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_outs("t6.stall1", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    chk_cnt("t6.pre", 32'd6, 32'd4);
    set_ex(1'b0, 1'b0, 5'd0);
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk_outs("t6.reset", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    chk_cnt("t6.reset", 32'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    chk_outs("t6.after", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    chk_cnt("t6.after", 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
